// File: rtl/jk_seq_pkg.sv
// Shared encodings and defaults for the JK command sequencer.
// Optional q checker is enabled with JK_SEQ_CHECK_EN.
package jk_seq_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } state_t;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO; an extra pointer MSB
// tells full from empty.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + (AW+1)'(1);
      if (pop && !empty)
        rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Buffers JK commands and plays each out as an enable burst plus one gap.
// Define JK_SEQ_CHECK_EN to add the q_in reference check and sticky err.
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             en,
  output logic             busy
`ifdef JK_SEQ_CHECK_EN
  ,
  input  logic             q_in,
  output logic             err
`endif
);

  localparam int W = 2 + LEN_W;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [W-1:0]     head;
  logic [1:0]       hop;
  logic [LEN_W-1:0] hlen;

  assign cmd_ready   = !full;
  assign push        = cmd_valid && !full;
  assign pop         = !empty && (state == IDLE || state == GAP);
  assign {hop, hlen} = head;

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({cmd_op, cmd_len}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      j     <= 1'b0;
      k     <= 1'b0;
      en    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, GAP: begin
          if (!empty) begin
            cnt  <= hlen;
            busy <= 1'b1;
            if (hlen != '0) begin
              state  <= DRIVE;
              {j, k} <= hop;
              en     <= 1'b1;
            end else begin
              // zero-length command: just one gap cycle
              state  <= GAP;
              {j, k} <= 2'b00;
              en     <= 1'b0;
            end
          end else begin
            state  <= IDLE;
            {j, k} <= 2'b00;
            en     <= 1'b0;
            busy   <= push;
          end
        end
        DRIVE: begin
          busy <= 1'b1;
          if (cnt == LEN_W'(1)) begin
            state  <= GAP;
            {j, k} <= 2'b00;
            en     <= 1'b0;
          end else begin
            cnt <= cnt - LEN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JK_SEQ_CHECK_EN
  logic exp_q;
  logic model_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q       <= 1'b0;
      model_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (en) begin
        unique case ({j, k})
          OP_RST:  exp_q <= 1'b0;
          OP_SET:  exp_q <= 1'b1;
          OP_TGL:  exp_q <= ~exp_q;
          default: exp_q <= exp_q;
        endcase
      end
      // j != k during drive means a set or reset is completing
      if (state == DRIVE && cnt == LEN_W'(1) && j != k)
        model_valid <= 1'b1;
      if (state == GAP && model_valid && q_in != exp_q)
        err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer: expected bursts are queued
// on push and compared when the enable burst ends.
module tb_jk_cmd_sequencer;
  import jk_seq_pkg::*;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] len;
  } burst_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_len = 8'd0;
  logic       j;
  logic       k;
  logic       en;
  logic       busy;

  int checks = 0;
  int errors = 0;

  burst_t     sb[$];
  int         run = 0;
  int         lowrun = 0;
  logic [1:0] run_op = 2'b00;
  bit         had_burst = 0;
  bit         gap_on = 0;

`ifdef JK_SEQ_CHECK_EN
  logic q_ff;
  logic q_in;
  logic err;
  logic corrupt = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_ff <= 1'b0;
    else if (en) begin
      case ({j, k})
        2'b01:   q_ff <= 1'b0;
        2'b10:   q_ff <= 1'b1;
        2'b11:   q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
    end
  end

  assign q_in = q_ff ^ corrupt;
`endif

  jk_cmd_sequencer #(
    .DEPTH (4),
    .LEN_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .j         (j),
    .k         (k),
    .en        (en),
    .busy      (busy)
`ifdef JK_SEQ_CHECK_EN
    ,
    .q_in      (q_in),
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int unsigned got,
                       input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Burst monitor: measures each enable run and its preceding gap.
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
      lowrun = 0;
      had_burst = 0;
    end else if (en) begin
      if (run == 0) begin
        run_op = {j, k};
        if (gap_on && had_burst)
          check("gap_len", lowrun, 1);
      end else begin
        check("op_stable", {j, k}, run_op);
      end
      run++;
    end else begin
      if (run > 0) begin
        if (sb.size() == 0) begin
          check("unexpected_burst", run, 0);
        end else begin
          burst_t e;
          e = sb.pop_front();
          check("burst_op", run_op, e.op);
          check("burst_len", run, e.len);
        end
        run = 0;
        lowrun = 0;
        had_burst = 1;
      end
      lowrun++;
    end
  end

  task automatic push(input logic [1:0] op,
                      input logic [7:0] len,
                      output int waited);
    int t;
    t = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    while (!cmd_ready && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", cmd_ready, 1);
    @(posedge clk);
    if (len != 8'd0)
      sb.push_back('{op: op, len: len});
    #1 cmd_valid = 1'b0;
    waited = t;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while ((busy || en) && t < 2000);
    check("idle_busy", busy, 0);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int w;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_en", en, 0);
    check("rst_jk", {j, k}, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
`ifdef JK_SEQ_CHECK_EN
    check("rst_err", err, 0);
`endif
    @(negedge clk);
    #1 rst = 1'b0;

    // set len 3: latency, burst, single gap, busy fall
    push(OP_SET, 8'd3, w);
    @(negedge clk);
    check("t1_en_pre", en, 0);
    check("t1_busy_on", busy, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_en", en, 1);
      check("t1_jk", {j, k}, 2'b10);
    end
    @(negedge clk);
    check("t1_gap_en", en, 0);
    check("t1_gap_busy", busy, 1);
    @(negedge clk);
    check("t1_busy_off", busy, 0);
    wait_idle();

    // fill the FIFO behind a long command
    gap_on = 1;
    had_burst = 0;
    push(OP_TGL, 8'd20, w);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!en && w < 10);
    check("t2_started", en, 1);
    push(OP_SET, 8'd2, w);
    push(OP_RST, 8'd3, w);
    push(OP_HOLD, 8'd1, w);
    push(OP_TGL, 8'd4, w);
    @(negedge clk);
    check("t2_full_ready", cmd_ready, 0);
    check("t2_full_busy", busy, 1);
    push(OP_SET, 8'd5, w);
    check("t2_fifth_waited", (w > 0) ? 1 : 0, 1);
    wait_idle();
    gap_on = 0;

    // zero-length toggle then set len 1
    push(OP_TGL, 8'd0, w);
    push(OP_SET, 8'd1, w);
    @(negedge clk);
    check("t3_en_gap", en, 0);
    @(negedge clk);
    check("t3_en", en, 1);
    check("t3_jk", {j, k}, 2'b10);
    @(negedge clk);
    check("t3_en_off", en, 0);
    wait_idle();

    // reset in the middle of a max-length burst
    push(OP_TGL, 8'd255, w);
    push(OP_SET, 8'd2, w);
    w = 0;
    do begin
      @(negedge clk);
      #1;
      w++;
    end while (run < 100 && w < 400);
    check("t4_reached", run, 100);
    rst = 1'b1;
    #1;
    check("t4_en", en, 0);
    check("t4_jk", {j, k}, 0);
    check("t4_busy", busy, 0);
    check("t4_ready", cmd_ready, 1);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    push(OP_RST, 8'd2, w);
    wait_idle();

    // random mix
    for (int i = 0; i < 8; i++)
      push(2'($urandom_range(0, 3)), 8'($urandom_range(0, 6)), w);
    wait_idle();

`ifdef JK_SEQ_CHECK_EN
    push(OP_SET, 8'd1, w);
    push(OP_TGL, 8'd3, w);
    wait_idle();
    check("chk_err_clean", err, 0);
    corrupt = 1'b1;
    push(OP_HOLD, 8'd1, w);
    wait_idle();
    check("chk_err_set", err, 1);
    repeat (3) @(negedge clk);
    check("chk_err_sticky", err, 1);
    rst = 1'b1;
    #1;
    check("chk_err_rst", err, 0);
    corrupt = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
